mem_reg_sequencer: RTL and testbench

MEM_REG_SEQUENCER -- requirements
Module: mem_reg_sequencer

---
 rtl/mem_reg_pkg.sv | 39 +++
 rtl/mem_reg_decode.sv | 23 ++
 rtl/mem_reg_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_mem_reg_sequencer.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_reg_pkg.sv
// Shared definitions for the memory/register-file instruction sequencer.
//   - Instruction field bit positions: [31:30] op, [29:20] A, [19:10] B, [9:0] C
//   - op_t    : opcode encoding
//   - state_t : sequencer FSM states
//   - imm_zext: zero-extended 20-bit immediate {B,C} used by LOADI
package mem_reg_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 10;

  localparam int OP_MSB = 31;
  localparam int OP_LSB = 30;
  localparam int A_MSB  = 29;
  localparam int A_LSB  = 20;
  localparam int B_MSB  = 19;
  localparam int B_LSB  = 10;
  localparam int C_MSB  = 9;
  localparam int C_LSB  = 0;

  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_LOAD  = 2'b01,
    OP_STORE = 2'b10,
    OP_LOADI = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    DECODE = 2'b01,
    READ   = 2'b10,
    WRITE  = 2'b11
  } state_t;

  function automatic logic [INSTR_W-1:0] imm_zext(input logic [ADDR_W-1:0] b,
                                                  input logic [ADDR_W-1:0] c);
    return {12'd0, b, c};
  endfunction

endpackage

// File: rtl/mem_reg_decode.sv
// Combinational instruction-field extraction.
// Ports:
//   instr - captured 32-bit instruction word
//   op    - opcode field [31:30]
//   a     - A field [29:20] (register address)
//   b     - B field [19:10] (memory address / immediate high part)
//   imm   - zero-extended immediate {B,C}
module mem_reg_decode
  import mem_reg_pkg::*;
(
  input  logic [31:0] instr,
  output logic [1:0]  op,
  output logic [9:0]  a,
  output logic [9:0]  b,
  output logic [31:0] imm
);

  assign op  = instr[OP_MSB:OP_LSB];
  assign a   = instr[A_MSB:A_LSB];
  assign b   = instr[B_MSB:B_LSB];
  assign imm = imm_zext(instr[B_MSB:B_LSB], instr[C_MSB:C_LSB]);

endmodule

// File: rtl/mem_reg_sequencer.sv
// Instruction sequencer driving a memory / register-file datapath.
// Accepts one instruction at a time (valid/ready), decodes it and walks
// IDLE -> DECODE -> [READ x READ_LAT] -> WRITE, issuing a one-cycle write
// strobe. Out-of-range memory addresses abort the instruction with err.
// Optional feature: define SEQ_PERF_CNT_EN to build the 16-bit
// instruction counter; otherwise instr_count is tied to 0.
// Parameters:
//   READ_LAT  - datapath read latency in cycles (1..4)
//   MEM_DEPTH - number of valid memory words
// Ports:
//   clk, rst_n                         - clock, synchronous active-low reset
//   instr, instr_valid, instr_ready    - instruction handshake
//   address_mem/reg/reg1/reg2          - datapath addresses
//   data_in, data_in_reg               - immediate data to memory / reg file
//   enable                             - one-cycle write strobe
//   memory_input_selection             - 1: memory written from data_reg1
//   reg_input_selection                - 1: register written from data_mem/imm
//   busy, err, instr_count             - status
module mem_reg_sequencer
  import mem_reg_pkg::*;
#(
  parameter int READ_LAT  = 1,
  parameter int MEM_DEPTH = 1024
)(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  output logic [9:0]  address_mem,
  output logic [9:0]  address_reg,
  output logic [9:0]  address_reg1,
  output logic [9:0]  address_reg2,
  output logic [31:0] data_in,
  output logic [31:0] data_in_reg,
  output logic        enable,
  output logic        memory_input_selection,
  output logic        reg_input_selection,
  output logic        busy,
  output logic        err,
  output logic [15:0] instr_count
);

  localparam logic [1:0] LAT_INIT = 2'(READ_LAT - 1);

  state_t      state;
  state_t      next_state;
  logic [31:0] instr_q;
  logic [1:0]  lat_cnt;
  logic [1:0]  op_raw;
  op_t         op;
  logic [9:0]  fa;
  logic [9:0]  fb;
  logic [31:0] imm;
  logic        addr_bad;

  // Capture stage: instruction register (data, no reset needed)
  always_ff @(posedge clk) begin
    if (instr_valid && instr_ready) begin
      instr_q <= instr;
    end
  end

  mem_reg_decode u_decode (
    .instr (instr_q),
    .op    (op_raw),
    .a     (fa),
    .b     (fb),
    .imm   (imm)
  );

  assign op       = op_t'(op_raw);
  assign addr_bad = ((op == OP_LOAD) || (op == OP_STORE)) &&
                    ({22'd0, fb} >= 32'(MEM_DEPTH));

  // Control stage: state register and read-latency down-counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      lat_cnt <= 2'd0;
    end else begin
      state <= next_state;
      if (state == DECODE) begin
        lat_cnt <= LAT_INIT;
      end else if ((state == READ) && (lat_cnt != 2'd0)) begin
        lat_cnt <= lat_cnt - 2'd1;
      end
    end
  end

  always_comb begin
    next_state  = state;
    instr_ready = 1'b0;
    busy        = 1'b1;
    enable      = 1'b0;
    err         = 1'b0;
    case (state)
      IDLE: begin
        instr_ready = 1'b1;
        busy        = 1'b0;
        if (instr_valid) begin
          next_state = DECODE;
        end
      end
      DECODE: begin
        case (op)
          OP_NOP:   next_state = IDLE;
          OP_LOADI: next_state = WRITE;
          default: begin
            if (addr_bad) begin
              err        = 1'b1;
              next_state = IDLE;
            end else begin
              next_state = READ;
            end
          end
        endcase
      end
      READ: begin
        if (lat_cnt == 2'd0) begin
          next_state = WRITE;
        end
      end
      WRITE: begin
        // Gated by rst_n so a reset landing on WRITE never commits a write.
        enable     = rst_n;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Datapath drive: fields held from DECODE through WRITE, zero in IDLE.
  // No opcode writes immediate data to memory, so data_in stays 0.
  always_comb begin
    address_mem            = 10'd0;
    address_reg            = 10'd0;
    address_reg1           = 10'd0;
    address_reg2           = 10'd0;
    data_in                = 32'd0;
    data_in_reg            = 32'd0;
    memory_input_selection = 1'b0;
    reg_input_selection    = 1'b0;
    if (state != IDLE) begin
      case (op)
        OP_LOAD: begin
          address_mem         = fb;
          address_reg         = fa;
          reg_input_selection = 1'b1;
        end
        OP_STORE: begin
          address_reg1           = fa;
          address_mem            = fb;
          memory_input_selection = 1'b1;
        end
        OP_LOADI: begin
          address_reg         = fa;
          data_in_reg         = imm;
          reg_input_selection = 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef SEQ_PERF_CNT_EN
  logic [15:0] cnt_q;

  // Counts completed writes and NOPs; wraps naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= 16'd0;
    end else if ((state == WRITE) || ((state == DECODE) && (op == OP_NOP))) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign instr_count = cnt_q;
`else
  assign instr_count = 16'd0;
`endif

endmodule

// File: tb/tb_mem_reg_sequencer.sv
module tb_mem_reg_sequencer;

  localparam int RL = 2;
  localparam int MD = 512;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [9:0]  address_mem;
  logic [9:0]  address_reg;
  logic [9:0]  address_reg1;
  logic [9:0]  address_reg2;
  logic [31:0] data_in;
  logic [31:0] data_in_reg;
  logic        enable;
  logic        memory_input_selection;
  logic        reg_input_selection;
  logic        busy;
  logic        err;
  logic [15:0] instr_count;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] exp_cnt = 16'd0;

  always #5 clk = ~clk;

  mem_reg_sequencer #(
    .READ_LAT  (RL),
    .MEM_DEPTH (MD)
  ) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .instr                  (instr),
    .instr_valid            (instr_valid),
    .instr_ready            (instr_ready),
    .address_mem            (address_mem),
    .address_reg            (address_reg),
    .address_reg1           (address_reg1),
    .address_reg2           (address_reg2),
    .data_in                (data_in),
    .data_in_reg            (data_in_reg),
    .enable                 (enable),
    .memory_input_selection (memory_input_selection),
    .reg_input_selection    (reg_input_selection),
    .busy                   (busy),
    .err                    (err),
    .instr_count            (instr_count)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] addr_vec();
    return {24'd0, address_mem, address_reg, address_reg1, address_reg2};
  endfunction

  function automatic logic [15:0] exp_count();
`ifdef SEQ_PERF_CNT_EN
    return exp_cnt;
`else
    return 16'd0;
`endif
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_rdy"},  {busy, instr_ready}, 2'b01);
    check({tag, "_en"},   {enable, err}, 2'b00);
    check({tag, "_addr"}, addr_vec(), 64'd0);
    check({tag, "_data"}, {data_in, data_in_reg}, 64'd0);
    check({tag, "_sel"},  {memory_input_selection, reg_input_selection}, 2'b00);
    check({tag, "_cnt"},  instr_count, exp_count());
  endtask

  // Called just after a falling edge with the DUT expected in IDLE.
  // hold=1 keeps the same instruction valid throughout (streaming).
  task automatic run_instr(input logic [1:0] op, input logic [9:0] a,
                           input logic [9:0] b, input logic [9:0] c, input bit hold);
    bit          bad;
    bit          wr;
    int          lat;
    int          waits;
    logic [63:0] e_addr;
    logic [63:0] e_data;
    logic [1:0]  e_sel;
    bad    = ((op == 2'b01) || (op == 2'b10)) && (int'(b) >= MD);
    wr     = (op != 2'b00) && !bad;
    lat    = !wr ? 1 : ((op == 2'b11) ? 2 : 2 + RL);
    e_addr = {24'd0, ((op == 2'b01) || (op == 2'b10)) ? b : 10'd0,
                     ((op == 2'b01) || (op == 2'b11)) ? a : 10'd0,
                     (op == 2'b10) ? a : 10'd0, 10'd0};
    e_data = {32'd0, (op == 2'b11) ? {12'd0, b, c} : 32'd0};
    e_sel  = {op == 2'b10, (op == 2'b01) || (op == 2'b11)};
    instr       = {op, a, b, c};
    instr_valid = 1'b1;
    waits = 0;
    while (!instr_ready && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    check("hs_wait", waits, 0);
    if (!instr_ready) begin
      instr_valid = 1'b0;
      return;
    end
    for (int j = 1; j <= lat + 1; j++) begin
      @(negedge clk);
      if (j == 1 && !hold) begin
        instr       = $urandom;
        instr_valid = 1'($urandom_range(0, 1));
      end
      if (j <= lat) begin
        check("busy",   {busy, instr_ready}, 2'b10);
        check("enable", enable, 64'(wr && (j == lat)));
        check("err",    err, 64'(bad && (j == 1)));
        check("addr",   addr_vec(), e_addr);
        check("data",   {data_in, data_in_reg}, e_data);
        check("sel",    {memory_input_selection, reg_input_selection}, e_sel);
      end else begin
        if (op == 2'b00 || wr) exp_cnt++;
        check_idle("post");
        if (!hold) instr_valid = 1'b0;
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n       = 1'b0;
    instr       = 32'd0;
    instr_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_idle("rst");
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("rel");

    // LOADI A=5, immediate {B,C} = 29839
    run_instr(2'b11, 10'd5, 10'd29, 10'd143, 1'b0);
    // LOAD A=3, B=7
    run_instr(2'b01, 10'd3, 10'd7, 10'd0, 1'b0);
    // STORE out of range
    run_instr(2'b10, 10'd5, 10'd1023, 10'd0, 1'b0);
    // STORE at the last valid word
    run_instr(2'b10, 10'd9, 10'd511, 10'd0, 1'b0);
    // NOP stream with valid held high
    begin
      logic [9:0] na;
      logic [9:0] nb;
      logic [9:0] nc;
      na = 10'($urandom);
      nb = 10'($urandom);
      nc = 10'($urandom);
      for (int i = 0; i < 8; i++) run_instr(2'b00, na, nb, nc, 1'b1);
    end
    instr_valid = 1'b0;

    for (int i = 0; i < 60; i++) begin
      run_instr(2'($urandom_range(0, 3)), 10'($urandom), 10'($urandom),
                10'($urandom), 1'b0);
    end

    // Reset during READ of a LOAD
    instr       = {2'b01, 10'd9, 10'd20, 10'd0};
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    check("rd_busy", {busy, enable}, 2'b10);
    rst_n = 1'b0;
    exp_cnt = 16'd0;
    @(negedge clk);
    check_idle("rst_rd");
    @(negedge clk);
    check("rst_rd_en2", enable, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_rd_rdy", instr_ready, 64'd1);
    check("rel_rd_en", enable, 64'd0);
    run_instr(2'b11, 10'd1, 10'd2, 10'd3, 1'b0);

`ifdef SEQ_PERF_CNT_EN
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_cnt = 16'd0;
    @(negedge clk);
    instr       = 32'd0;
    instr_valid = 1'b1;
    for (int i = 0; i < 65536; i++) begin
      @(negedge clk);
      @(negedge clk);
      if (i == 65534) check("cnt_ffff", instr_count, 64'hffff);
    end
    instr_valid = 1'b0;
    check("cnt_wrap", instr_count, 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
